// File: rtl/nand_bus_responder.sv
// NAND flash target bus responder: decodes host latches on a synchronized bus,
// drives the page-buffer port and the array read/program handshake.
module nand_bus_responder #(
  parameter int          PAGE_BYTES = 64,
  parameter int          T_R_CYC    = 40,
  parameter int          T_PROG_CYC = 100,
  parameter int          T_RST_CYC  = 20,
  parameter logic [39:0] ID_BYTES   = 40'h00_A6_64_D3_2C
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          ce_n,
  input  logic                          cle,
  input  logic                          ale,
  input  logic                          we_n,
  input  logic                          re_n,
  input  logic                          wp_n,
  input  logic [7:0]                    dq_in,
  output logic [7:0]                    dq_out,
  output logic                          dq_oe,
  output logic                          rb_n,
  output logic [$clog2(PAGE_BYTES)-1:0] buf_addr,
  output logic                          buf_wr,
  output logic [7:0]                    buf_wdata,
  input  logic [7:0]                    buf_rdata,
  output logic [23:0]                   row_addr,
  output logic [1:0]                    array_op
);
  localparam int AW = $clog2(PAGE_BYTES);
  localparam logic [4:0] SYNC_IDLE = 5'b11001;  // {re_n, we_n, ale, cle, ce_n}

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DIN, S_BUSY, S_OUT_ID, S_OUT_STAT, S_OUT_PAGE
  } state_t;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_READ = 2'b01, OP_PROG = 2'b10, OP_RST = 2'b11} op_t;

  logic [4:0]    r_sync1, r_sync2;
  logic          r_we_d, r_re_d;
  state_t        r_state, r_prev, w_state_nxt, w_prev_nxt, w_cur, w_done_state;
  logic [7:0]    r_cmd;
  logic [2:0]    r_addr_cnt, r_id_idx;
  logic [AW-1:0] r_col;
  logic [23:0]   r_row;
  logic [15:0]   r_busy_cnt, w_start_len;
  op_t           r_busy_op, w_start_op;
  logic          r_rb_n, r_fail, r_buf_wr;
  logic [1:0]    r_array_op;
  logic [7:0]    r_buf_wdata, r_dq_out, w_dq_nxt;
  logic          w_start, w_fail_set, w_fail_clr, w_addr_clr, w_addr_store, w_write, w_id_clr;
  logic          w_dq_oe;

  wire w_ce_n = r_sync2[0];
  wire w_cle  = r_sync2[1];
  wire w_ale  = r_sync2[2];
  wire w_we_n = r_sync2[3];
  wire w_re_n = r_sync2[4];

  wire w_latch     = ~w_ce_n & w_we_n & ~r_we_d;
  wire w_is_cmd    = w_latch & w_cle & ~w_ale;
  wire w_is_addr   = w_latch & w_ale & ~w_cle;
  wire w_is_data   = w_latch & ~w_ale & ~w_cle;
  wire w_rd_rise   = ~w_ce_n & w_re_n & ~r_re_d;
  wire w_page_adv  = w_rd_rise & (r_state == S_OUT_PAGE);
  wire w_busy_done = ~r_rb_n & (r_busy_cnt == 16'd0);
  wire [15:0] w_col16 = 16'(r_col);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= SYNC_IDLE;
      r_sync2 <= SYNC_IDLE;
      r_we_d  <= 1'b1;
      r_re_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop samples the previous stage's old value.
      r_sync1 <= {re_n, we_n, ale, cle, ce_n};
      r_sync2 <= r_sync1;
      r_we_d  <= w_we_n;
      r_re_d  <= w_re_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_prev  <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
    end
  end

  assign w_done_state = (r_busy_op == OP_READ) ? S_OUT_PAGE : S_IDLE;

  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_start      = 1'b0;
    w_start_op   = OP_NONE;
    w_start_len  = 16'd0;
    w_fail_set   = 1'b0;
    w_fail_clr   = 1'b0;
    w_addr_clr   = 1'b0;
    w_addr_store = 1'b0;
    w_write      = 1'b0;
    w_id_clr     = 1'b0;
    if (w_busy_done) begin
      if (r_state == S_BUSY) w_state_nxt = w_done_state;
      else if (r_state == S_OUT_STAT && r_prev == S_BUSY) w_prev_nxt = w_done_state;
    end
    // Status mode is an overlay: decode against the state it interrupted.
    w_cur = (w_state_nxt == S_OUT_STAT) ? w_prev_nxt : w_state_nxt;
    if (w_is_cmd) begin
      if (dq_in == 8'hFF) begin
        w_state_nxt = S_BUSY;
        w_start     = 1'b1;
        w_start_op  = OP_RST;
        w_start_len = 16'(T_RST_CYC - 1);
        w_fail_clr  = 1'b1;
        w_addr_clr  = 1'b1;
      end else if (dq_in == 8'h70) begin
        w_prev_nxt  = w_cur;
        w_state_nxt = S_OUT_STAT;
      end else if (w_cur == S_BUSY) begin
        w_state_nxt = S_BUSY;
      end else begin
        w_addr_clr  = 1'b1;
        w_state_nxt = S_IDLE;
        case (dq_in)
          8'h00, 8'h80, 8'h90: w_state_nxt = S_ADDR;
          8'h30: if (w_cur == S_ADDR && r_cmd == 8'h00) begin
            w_state_nxt = S_BUSY;
            w_start     = 1'b1;
            w_start_op  = OP_READ;
            w_start_len = 16'(T_R_CYC - 1);
          end
          8'h10: if (w_cur == S_DIN) begin
            if (wp_n) begin
              w_state_nxt = S_BUSY;
              w_start     = 1'b1;
              w_start_op  = OP_PROG;
              w_start_len = 16'(T_PROG_CYC - 1);
              w_fail_clr  = 1'b1;
            end else begin
              w_fail_set  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (w_is_addr && w_state_nxt == S_ADDR) begin
      w_addr_store = (r_addr_cnt < 3'd5);
      if (r_cmd == 8'h90) begin
        w_state_nxt = S_OUT_ID;
        w_id_clr    = 1'b1;
      end
    end else if (w_is_data && (w_state_nxt == S_DIN || (w_state_nxt == S_ADDR && r_cmd == 8'h80))) begin
      w_state_nxt = S_DIN;
      w_write     = wp_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rb_n      <= 1'b1;
      r_busy_cnt  <= 16'd0;
      r_busy_op   <= OP_NONE;
      r_array_op  <= 2'b00;
      r_fail      <= 1'b0;
      r_cmd       <= 8'h00;
      r_addr_cnt  <= 3'd0;
      r_id_idx    <= 3'd0;
      r_col       <= '0;
      r_row       <= 24'd0;
      r_buf_wr    <= 1'b0;
      r_buf_wdata <= 8'h00;
    end else begin
      r_array_op <= 2'b00;
      r_buf_wr   <= 1'b0;
      if (w_start) begin
        r_rb_n     <= 1'b0;
        r_busy_op  <= w_start_op;
        r_busy_cnt <= w_start_len;
        if (w_start_op != OP_RST) r_array_op <= w_start_op;
      end else if (w_busy_done) begin
        r_rb_n <= 1'b1;
      end else if (!r_rb_n) begin
        r_busy_cnt <= r_busy_cnt - 1'b1;
      end
      if (w_fail_set) r_fail <= 1'b1;
      else if (w_fail_clr) r_fail <= 1'b0;
      if (w_addr_clr) begin
        r_addr_cnt <= 3'd0;
        r_cmd      <= dq_in;
      end else if (w_addr_store) begin
        r_addr_cnt <= r_addr_cnt + 1'b1;
        case (r_addr_cnt)
          3'd2:    r_row[7:0]   <= dq_in;
          3'd3:    r_row[15:8]  <= dq_in;
          3'd4:    r_row[23:16] <= dq_in;
          default: ;
        endcase
      end
      // Column bits above the page size are dropped: the column is kept mod PAGE_BYTES.
      if (w_addr_store && r_addr_cnt == 3'd0) r_col <= AW'({8'h00, dq_in});
      else if (w_addr_store && r_addr_cnt == 3'd1) r_col <= AW'({dq_in, 8'h00} | w_col16);
      else if (r_buf_wr || w_page_adv) r_col <= r_col + 1'b1;
      if (w_id_clr) r_id_idx <= 3'd0;
      else if (w_rd_rise && r_state == S_OUT_ID && r_id_idx != 3'd5) r_id_idx <= r_id_idx + 1'b1;
      if (w_write) begin
        r_buf_wr    <= 1'b1;
        r_buf_wdata <= dq_in;
      end
    end
  end

  always_comb begin
    w_dq_nxt = 8'h00;
    case (r_state)
      S_OUT_ID:   if (r_id_idx < 3'd5) w_dq_nxt = 8'(ID_BYTES >> {r_id_idx, 3'b000});
      S_OUT_STAT: w_dq_nxt = {wp_n, r_rb_n, r_rb_n, 4'b0000, r_fail};
      S_OUT_PAGE: w_dq_nxt = buf_rdata;
      default:    w_dq_nxt = 8'h00;
    endcase
    w_dq_oe = ~w_ce_n & ~w_re_n & (r_state inside {S_OUT_ID, S_OUT_STAT, S_OUT_PAGE});
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_dq_out <= 8'h00;
    else        r_dq_out <= w_dq_nxt;
  end

  assign dq_out    = r_dq_out;
  assign dq_oe     = w_dq_oe;
  assign rb_n      = r_rb_n;
  assign buf_addr  = r_col;
  assign buf_wr    = r_buf_wr;
  assign buf_wdata = r_buf_wdata;
  assign row_addr  = r_row;
  assign array_op  = r_array_op;
endmodule
